// File: rtl/sram_seg_sched_pkg.sv
// Shared types and constants for the segmented-SRAM scheduler.
//   - state_t : scheduler FSM states (also exported on the debug port)
//   - grant_t : identity of the requester that was granted last
//   - line_t  : one full 128-bit SRAM line (NSEG segments of SEG_W bits)
// TIMEOUT_CYC is only referenced when SRAM_TIMEOUT_EN is defined.
package sram_sched_pkg;
  localparam int SEG_W       = 16;
  localparam int NSEG        = 8;
  localparam int SEL_W       = 3;
  localparam int ADDR_W      = 4;
  localparam int LINE_W      = SEG_W * NSEG;
  localparam int TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN_XFER = 3'd1,
    SCAN_DONE = 3'd2,
    CORE_XFER = 3'd3,
    CORE_DONE = 3'd4
  } state_t;

  typedef enum logic {
    SCAN = 1'b0,
    CORE = 1'b1
  } grant_t;

  typedef logic [LINE_W-1:0] line_t;
endpackage

// File: rtl/sram_seg_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (last grant -> CORE)
//   i_req_scan     : scan requester pending
//   i_req_core     : core requester pending
//   i_grant_en     : arbitration allowed this cycle (scheduler idle)
//   o_gnt_scan/core: one-hot grant, combinational, only while i_grant_en
// When both requests are pending the requester that was not granted last
// wins; the last-grant register only moves on an actual grant.
module rr_arb2
  import sram_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_scan,
  input  logic i_req_core,
  input  logic i_grant_en,
  output logic o_gnt_scan,
  output logic o_gnt_core
);
  grant_t r_last;

  always_comb begin
    o_gnt_scan = 1'b0;
    o_gnt_core = 1'b0;
    if (i_grant_en) begin
      if (i_req_scan && i_req_core) begin
        if (r_last == CORE) o_gnt_scan = 1'b1;
        else                o_gnt_core = 1'b1;
      end else begin
        o_gnt_scan = i_req_scan;
        o_gnt_core = i_req_core;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= CORE;
    end else if (o_gnt_scan) begin
      r_last <= SCAN;
    end else if (o_gnt_core) begin
      r_last <= CORE;
    end
  end
endmodule

// File: rtl/sram_seg_sched.sv
// sram_seg_sched: schedules a scan single-segment port and a SIMD-core line
// port onto one segment-wide SRAM interface.
// Optional feature macro: SRAM_TIMEOUT_EN (abort an access after TIMEOUT_CYC
// cycles without sram_ready and raise sticky sram_err).
// Handshakes:
//   scan_ren/scan_wen and core_req are levels held by the requester until the
//   matching one-cycle completion pulse (scan_ready / core_ack). Read data is
//   valid with the pulse and held afterwards. The SRAM side presents
//   registered strobes that stay high until the cycle sram_ready = 1.
// Ports: clk, rst; scan_* (scan port); core_* (line port); sram_* (SRAM
//   segment interface); busy (not IDLE); sram_err; dbg_state (FSM state).
module sram_seg_sched
  import sram_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_ren,
  input  logic              scan_wen,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic [SEL_W-1:0]  scan_seg_sel,
  input  logic [SEG_W-1:0]  scan_wdata,
  output logic [SEG_W-1:0]  scan_rdata,
  output logic              scan_ready,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  line_t             core_wdata,
  output line_t             core_rdata,
  output logic              core_ack,
  output logic              sram_ren,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [SEL_W-1:0]  sram_seg_sel,
  output logic [SEG_W-1:0]  sram_wdata,
  input  logic [SEG_W-1:0]  sram_rdata,
  input  logic              sram_ready,
  output logic              busy,
  output logic              sram_err,
  output state_t            dbg_state
);
  state_t            r_state;
  logic              r_hold_scan;   // one-cycle holdoff after scan_ready
  logic              r_hold_core;   // one-cycle holdoff after core_ack
  logic              r_we;
  logic [SEL_W-1:0]  r_seg;
  line_t             r_line;
  line_t             r_core_wdata;

  logic              w_scan_req;
  logic              w_core_req;
  logic              w_gnt_scan;
  logic              w_gnt_core;
  logic              w_abort;
  logic              w_done;
  logic [SEG_W-1:0]  w_rdata_in;
  logic [SEL_W-1:0]  w_seg_nxt;
  line_t             w_line_next;

  assign w_scan_req = (scan_ren | scan_wen) & ~r_hold_scan;
  assign w_core_req = core_req & ~r_hold_core;
  assign w_done     = sram_ready | w_abort;
  // An aborted access returns zero rather than whatever is on the bus.
  assign w_rdata_in = w_abort ? '0 : sram_rdata;
  assign w_seg_nxt  = r_seg + 3'd1;
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req_scan (w_scan_req),
    .i_req_core (w_core_req),
    .i_grant_en (r_state == IDLE),
    .o_gnt_scan (w_gnt_scan),
    .o_gnt_core (w_gnt_core)
  );

  // Line buffer with the current segment merged in, so the last segment is
  // visible in core_rdata in the same cycle core_ack rises.
  always_comb begin
    w_line_next = r_line;
    w_line_next[int'(r_seg)*SEG_W +: SEG_W] = w_rdata_in;
  end

`ifdef SRAM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  logic             w_xfer;

  assign w_xfer   = (r_state == SCAN_XFER) || (r_state == CORE_XFER);
  assign w_abort  = w_xfer && !sram_ready && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign sram_err = r_err;

  // Counts wait cycles of the segment currently presented; sram_ready (which
  // also issues the next segment) and leaving XFER restart it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_xfer && !sram_ready && !w_abort) r_tmo <= r_tmo + 1'b1;
      else                                    r_tmo <= '0;
      if (w_abort) r_err <= 1'b1;
    end
  end
`else
  assign w_abort  = 1'b0;
  assign sram_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hold_scan  <= 1'b0;
      r_hold_core  <= 1'b0;
      r_we         <= 1'b0;
      r_seg        <= '0;
      r_line       <= '0;
      r_core_wdata <= '0;
      scan_rdata   <= '0;
      scan_ready   <= 1'b0;
      core_rdata   <= '0;
      core_ack     <= 1'b0;
      sram_ren     <= 1'b0;
      sram_wen     <= 1'b0;
      sram_addr    <= '0;
      sram_seg_sel <= '0;
      sram_wdata   <= '0;
    end else begin
      scan_ready  <= 1'b0;
      core_ack    <= 1'b0;
      r_hold_scan <= 1'b0;
      r_hold_core <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_scan) begin
            // Write wins when both scan strobes are set.
            sram_ren     <= ~scan_wen;
            sram_wen     <= scan_wen;
            sram_addr    <= scan_addr;
            sram_seg_sel <= scan_seg_sel;
            sram_wdata   <= scan_wdata;
            r_state      <= SCAN_XFER;
          end else if (w_gnt_core) begin
            sram_ren     <= ~core_we;
            sram_wen     <= core_we;
            sram_addr    <= core_addr;
            sram_seg_sel <= '0;
            sram_wdata   <= core_wdata[SEG_W-1:0];
            r_core_wdata <= core_wdata;
            r_we         <= core_we;
            r_seg        <= '0;
            r_line       <= '0;
            r_state      <= CORE_XFER;
          end
        end
        SCAN_XFER: begin
          if (w_done) begin
            if (!sram_wen) scan_rdata <= w_rdata_in;
            sram_ren   <= 1'b0;
            sram_wen   <= 1'b0;
            scan_ready <= 1'b1;
            r_state    <= SCAN_DONE;
          end
        end
        SCAN_DONE: begin
          r_hold_scan <= 1'b1;
          r_state     <= IDLE;
        end
        CORE_XFER: begin
          if (w_done) begin
            if (!r_we) r_line <= w_line_next;
            if ((r_seg == SEL_W'(NSEG - 1)) || w_abort) begin
              sram_ren <= 1'b0;
              sram_wen <= 1'b0;
              core_ack <= 1'b1;
              if (!r_we) core_rdata <= w_line_next;
              r_state  <= CORE_DONE;
            end else begin
              // Strobes stay asserted; next segment goes out back-to-back.
              r_seg        <= w_seg_nxt;
              sram_seg_sel <= w_seg_nxt;
              sram_wdata   <= r_core_wdata[int'(w_seg_nxt)*SEG_W +: SEG_W];
            end
          end
        end
        CORE_DONE: begin
          r_hold_core <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sram_seg_sched.md
Name: sram_seg_sched

Overview:
Two-requester scheduler in front of the 128-bit segmented SRAM (16 words × 8 segments × 16 bits).
- Requester A: the scan-side single-segment port, driven by the existing scan read/write controller.
- Requester B: a SIMD-core line port. Each 128-bit line transfer is sequenced into 8 atomic segment accesses.
- Grants alternate round-robin between the two requesters and drive the single SRAM segment interface.

Parameters:
SEG_W, 16, segment data width
NSEG, 8, segments per line (seg_sel width = 3)
ADDR_W, 4, word address width
TIMEOUT_CYC, 64, max cycles waiting for sram_ready (used only with SRAM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
scan_ren  in  1  scan segment read request (level, held until scan_ready)
scan_wen  in  1  scan segment write request (level, held until scan_ready)
scan_addr  in  4  scan word address
scan_seg_sel  in  3  scan segment select
scan_wdata  in  16  scan write data
scan_rdata  out  16  scan read data, valid with scan_ready, held afterwards
scan_ready  out  1  one-cycle completion pulse
core_req  in  1  core line request (level, held until core_ack)
core_we  in  1  1 = line write, 0 = line read
core_addr  in  4  core word address
core_wdata  in  128  core line write data; segment k = bits [16k+15:16k]
core_rdata  out  128  core line read data, valid with core_ack, held afterwards
core_ack  out  1  one-cycle completion pulse
sram_ren, sram_wen  out  1 each  SRAM strobes (registered)
sram_addr  out  4  SRAM word address
sram_seg_sel  out  3  SRAM segment select
sram_wdata  out  16  SRAM write data
sram_rdata  in  16  SRAM read data, sampled when sram_ready = 1
sram_ready  in  1  SRAM segment access complete
busy  out  1  high in any state other than IDLE
sram_err  out  1  sticky timeout flag (0 without SRAM_TIMEOUT_EN)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, last_grant = CORE, holdoff = 0. Applies identically mid-operation: strobes low the following cycle, no ack/ready pulse, core_rdata cleared.
- States: IDLE, SCAN_XFER, SCAN_DONE, CORE_XFER, CORE_DONE.
- IDLE, request evaluation:
  - scan pending = scan_ren | scan_wen.
  - Both pending: grant the requester ≠ last_grant.
  - On grant: latch the request fields, load the sram_* registers, update last_grant, go to the XFER state. Strobes are visible the cycle after the grant.
- SCAN_XFER:
  - If scan_wen is set, the access is a write; scan_ren is ignored when both are set.
  - Outputs hold until the cycle where sram_ready = 1. In that cycle: capture sram_rdata (reads only), drop the strobes, go to SCAN_DONE.
- SCAN_DONE: scan_ready = 1 for one cycle, then IDLE.
- CORE_XFER:
  - Segment counter seg starts at 0. sram_seg_sel = seg; write data = core_wdata slice seg.
  - When sram_ready = 1:
    - Read: store sram_rdata into line-buffer slice seg.
    - seg < 7: seg+1, next segment presented next cycle with the strobe kept asserted.
    - seg = 7: strobes drop, go to CORE_DONE.
  - The line is atomic; scan requests wait.
- CORE_DONE: core_ack = 1 for one cycle; core_rdata updates on reads only. Then IDLE.
- Holdoff: in the cycle immediately after scan_ready or core_ack, that requester's request is ignored, so a request still held is not re-granted.
- Latency with sram_ready tied high:
  - scan: pulse 2 cycles after request sampled
  - core: ack 9 cycles after request sampled
- sram_ready outside an XFER state is ignored.

Optional Feature:
SRAM_TIMEOUT_EN:
- Defined:
  - A counter clears on each segment issue.
  - After TIMEOUT_CYC cycles without sram_ready, the transfer aborts: strobes drop, remaining core segments are skipped, DONE is entered normally, and the aborted segment's read data is 0.
  - sram_err sets and is cleared only by rst.
- Undefined: the block waits indefinitely; sram_err is tied 0.

Decomposition:
- Package sram_sched_pkg: state enum, grant enum {SCAN, CORE}, SEG_W/NSEG/ADDR_W localparams, line type logic [127:0].
- One sub-module, rr_arb2: 2-way round-robin arbiter with a last_grant register and grant-enable input.

Test Plan:
1. Scan write addr 4'h3, seg 3'h5, data 16'hA5A5, sram_ready tied 1 → sram_wen high in cycle 1 with addr 3 / seg 5 / wdata A5A5; scan_ready pulse in cycle 2; no re-grant in cycle 3.
2. Core read addr 4'hA, SRAM returns 16'h1000+seg_sel, ready tied 1 → seg_sel 0..7 in cycles 1..8; core_ack in cycle 9; core_rdata = {16'h1007,…,16'h1000}.
3. scan_ren and core_req both asserted after reset → scan served first, then core; both re-asserted → core first (alternation verified).
4. Core write with sram_ready delayed 3 cycles per segment → each seg_sel held 4 cycles with the correct 16-bit wdata slice; core_ack in cycle 33.
5. rst asserted during segment 4 of a core read → strobes 0 next cycle, state IDLE, no core_ack, core_rdata = 0.
6. With SRAM_TIMEOUT_EN, TIMEOUT_CYC = 16, scan read with sram_ready never asserted → scan_ready after 16 strobe cycles, scan_rdata = 0, sram_err = 1 until rst.
